// File: rtl/fc_stream_pkg.sv
// Shared constants for the 128-bit activation stream feeding the Layer-4 FC engine.
package fc_stream_pkg;

    localparam int DATA_W    = 16;
    localparam int LANES     = 8;
    localparam int BEAT_W    = DATA_W * LANES;
    localparam int L4_IN_LEN = 400;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEATS_PER_FRAME = ceil_div(L4_IN_LEN, LANES);
    localparam int LANE_IDX_W      = idx_w(LANES);
    localparam int ELEM_IDX_W      = idx_w(L4_IN_LEN);

endpackage

// File: rtl/fc_beat_out_reg.sv
// Single-entry AXI-Stream holding register; data and last hold until reloaded.
module fc_beat_out_reg #(
    parameter int W = 128
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic [W-1:0] data_q, data_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/layer4_act_packer.sv
// Packs 16-bit Layer-3 activations into 128-bit beats, zero-padding and flagging the last beat of each frame.
module layer4_act_packer
    import fc_stream_pkg::*;
#(
    parameter int DATA_W    = fc_stream_pkg::DATA_W,
    parameter int LANES     = fc_stream_pkg::LANES,
    parameter int FRAME_LEN = fc_stream_pkg::L4_IN_LEN
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [DATA_W-1:0]         s_Data_TDATA,
    input  logic                      s_Data_TVALID,
    output logic                      s_Data_TREADY,
    output logic [DATA_W*LANES-1:0]   a_Data_TDATA,
    output logic                      a_Data_TVALID,
    input  logic                      a_Data_TREADY,
    output logic                      a_Data_TLAST
);

    localparam int OUT_W  = DATA_W * LANES;
    localparam int LANE_W = idx_w(LANES);
    localparam int ELEM_W = idx_w(FRAME_LEN);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic              acc_last_q, acc_last_d;
    logic              acc_full_q, acc_full_d;
    logic              move;
    logic              in_xfer;

    assign move          = acc_full_q & (~a_Data_TVALID | a_Data_TREADY);
    assign s_Data_TREADY = ~acc_full_q | move;
    assign in_xfer       = s_Data_TVALID & s_Data_TREADY;

    // A move empties the accumulator first, so a same-cycle input lands in a clean lane 0.
    always_comb begin
        acc_d      = acc_q;
        acc_last_d = acc_last_q;
        acc_full_d = acc_full_q;
        lane_d     = lane_q;
        elem_d     = elem_q;
        if (move) begin
            acc_d      = '0;
            acc_last_d = 1'b0;
            acc_full_d = 1'b0;
        end
        if (in_xfer) begin
            acc_d[lane_q*DATA_W +: DATA_W] = s_Data_TDATA;
            if (elem_q == ELEM_W'(FRAME_LEN - 1)) begin
                elem_d     = '0;
                lane_d     = '0;
                acc_full_d = 1'b1;
                acc_last_d = 1'b1;
            end else begin
                elem_d = elem_q + 1'b1;
                if (lane_q == LANE_W'(LANES - 1)) begin
                    lane_d     = '0;
                    acc_full_d = 1'b1;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
        end
    end

    // NOTE: the accumulator is an ordinary register, so it takes the async reset like the counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lane_q     <= '0;
            elem_q     <= '0;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
            acc_full_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            elem_q     <= elem_d;
            acc_q      <= acc_d;
            acc_last_q <= acc_last_d;
            acc_full_q <= acc_full_d;
        end
    end

    fc_beat_out_reg #(
        .W(OUT_W)
    ) u_out (
        .clk_i   (ap_clk),
        .rst_n_i (ap_rst_n),
        .load_i  (move),
        .data_i  (acc_q),
        .last_i  (acc_last_q),
        .ready_i (a_Data_TREADY),
        .valid_o (a_Data_TVALID),
        .data_o  (a_Data_TDATA),
        .last_o  (a_Data_TLAST)
    );

endmodule

// File: tb/tb_layer4_act_packer.sv
// Drives a 400-element and a 20-element packer with the same stimulus style and checks beats against a frame model.
module tb_layer4_act_packer;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [15:0]  s_data  [2];
    logic         s_valid [2];
    logic         s_ready [2];
    logic         a_ready [2];
    logic         a_valid [2];
    logic         a_last  [2];
    logic [127:0] a_data  [2];

    layer4_act_packer #(.FRAME_LEN(400)) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_Data_TDATA(s_data[0]), .s_Data_TVALID(s_valid[0]), .s_Data_TREADY(s_ready[0]),
        .a_Data_TDATA(a_data[0]), .a_Data_TVALID(a_valid[0]), .a_Data_TREADY(a_ready[0]),
        .a_Data_TLAST(a_last[0])
    );

    layer4_act_packer #(.FRAME_LEN(20)) dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_Data_TDATA(s_data[1]), .s_Data_TVALID(s_valid[1]), .s_Data_TREADY(s_ready[1]),
        .a_Data_TDATA(a_data[1]), .a_Data_TVALID(a_valid[1]), .a_Data_TREADY(a_ready[1]),
        .a_Data_TLAST(a_last[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    int           frame_len [2] = '{400, 20};
    logic [15:0]  q0 [$];
    logic [15:0]  q1 [$];
    logic [127:0] obs0 [$];
    logic [127:0] obs1 [$];
    int           v_mode [2], r_mode [2], in_lim [2];
    int           sent [2], out_n [2], lasts [2], stalls [2];
    logic [15:0]  seq [2];
    bit           rnd_data;
    bit           held [2], hold_exp [2];
    logic [127:0] prev_d [2];
    logic         prev_l [2];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] qget(input int i, input int idx);
        return (i == 0) ? q0[idx] : q1[idx];
    endfunction

    // Beat n of the stream: frame n/nb, beat n%nb covers elements 8k..8k+7 of that frame, zero past the frame end.
    task automatic exp_beat(input int i, input int n, output logic [127:0] d, output logic l, output bit ok);
        int fl, nb, f, k, e;
        fl = frame_len[i];
        nb = (fl + 7) / 8;
        f  = n / nb;
        k  = n % nb;
        d  = '0;
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            e = 8 * k + j;
            if (e < fl) begin
                if (f * fl + e >= qsize(i)) ok = 1'b0;
                else d[16*j +: 16] = qget(i, f * fl + e);
            end
        end
        l = (k == nb - 1);
    endtask

    task automatic step();
        logic [127:0] ed;
        logic         el;
        bit           ok;
        @(negedge ap_clk);
        for (int i = 0; i < 2; i++) begin
            if (!held[i]) begin
                s_valid[i] = (sent[i] < in_lim[i]) &&
                             (v_mode[i] == 1 || (v_mode[i] == 2 && $urandom_range(0, 1) == 1));
                s_data[i]  = rnd_data ? 16'($urandom) : seq[i];
            end
            a_ready[i] = (r_mode[i] == 1) || (r_mode[i] == 2 && $urandom_range(0, 1) == 1);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hold_exp[i]) begin
                check($sformatf("d%0d_hold_valid", i), 128'(a_valid[i]), 128'd1);
                check($sformatf("d%0d_hold_data", i), a_data[i], prev_d[i]);
                check($sformatf("d%0d_hold_last", i), 128'(a_last[i]), 128'(prev_l[i]));
            end
            if (s_valid[i] && s_ready[i]) begin
                if (i == 0) q0.push_back(s_data[i]); else q1.push_back(s_data[i]);
                sent[i]++;
                seq[i]++;
                held[i] = 1'b0;
            end else begin
                held[i] = s_valid[i];
            end
            if (s_valid[i] && !s_ready[i]) stalls[i]++;
            if (a_valid[i] && a_ready[i]) begin
                exp_beat(i, out_n[i], ed, el, ok);
                check($sformatf("d%0d_beat%0d_avail", i, out_n[i]), 128'(ok), 128'd1);
                check($sformatf("d%0d_beat%0d_data", i, out_n[i]), a_data[i], ed);
                check($sformatf("d%0d_beat%0d_last", i, out_n[i]), 128'(a_last[i]), 128'(el));
                if (i == 0) obs0.push_back(a_data[i]); else obs1.push_back(a_data[i]);
                if (a_last[i]) lasts[i]++;
                out_n[i]++;
            end
            hold_exp[i] = a_valid[i] && !a_ready[i];
            prev_d[i]   = a_data[i];
            prev_l[i]   = a_last[i];
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic run_until_out(input int i, input int target, input int budget);
        for (int c = 0; c < budget && out_n[i] < target; c++) step();
        check($sformatf("d%0d_beat_count", i), 128'(out_n[i]), 128'(target));
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            a_ready[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_rst_valid", i), 128'(a_valid[i]), 128'd0);
            check($sformatf("d%0d_rst_data", i), a_data[i], 128'd0);
            check($sformatf("d%0d_rst_last", i), 128'(a_last[i]), 128'd0);
            check($sformatf("d%0d_rst_sready", i), 128'(s_ready[i]), 128'd1);
            sent[i] = 0; out_n[i] = 0; lasts[i] = 0; stalls[i] = 0;
            held[i] = 1'b0; hold_exp[i] = 1'b0; seq[i] = 16'd1;
        end
        q0.delete(); q1.delete(); obs0.delete(); obs1.delete();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_data[i] = '0; a_ready[i] = 1'b0;
            v_mode[i] = 0; r_mode[i] = 0; in_lim[i] = 0;
        end
        rnd_data = 1'b0;
        repeat (2) @(negedge ap_clk);
        do_reset();

        // Streaming at full rate; the 20-element packer sees two short frames.
        v_mode = '{1, 1}; r_mode = '{1, 1}; in_lim = '{400, 40};
        run_until_out(0, 50, 600);
        run_until_out(1, 6, 50);
        check("d0_no_stall", 128'(stalls[0]), 128'd0);
        check("d0_sent", 128'(sent[0]), 128'd400);
        check("d0_last_count", 128'(lasts[0]), 128'd1);
        check("d1_last_count", 128'(lasts[1]), 128'd2);
        check("d0_beat0_const", obs0.size() > 0 ? obs0[0] : 128'd0,
              128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("d1_beat2_padded", obs1.size() > 2 ? obs1[2] : 128'd0,
              128'h0000_0000_0000_0000_0014_0013_0012_0011);
        check("d1_frame2_lane0", obs1.size() > 3 ? 128'(obs1[3][15:0]) : 128'd0, 128'd21);

        // Backpressure from the start: two beats fill up, then input stalls.
        do_reset();
        v_mode = '{1, 1}; r_mode = '{0, 0}; in_lim = '{40, 40};
        run(30);
        check("d0_bp_accepted", 128'(sent[0]), 128'd16);
        check("d1_bp_accepted", 128'(sent[1]), 128'd16);
        check("d0_bp_sready", 128'(s_ready[0]), 128'd0);
        r_mode[0] = 1;
        step();
        step();
        check("d0_move_valid", 128'(a_valid[0]), 128'd1);
        check("d0_move_lane0", 128'(a_data[0][15:0]), 128'd9);
        run_until_out(0, 5, 200);
        check("d0_move_cycle_input_lane0", obs0.size() > 2 ? 128'(obs0[2][15:0]) : 128'd0, 128'd17);
        r_mode[1] = 1;
        run_until_out(1, 6, 200);
        check("d1_bp_last_count", 128'(lasts[1]), 128'd2);

        // Random valid/ready and random data over three frames.
        do_reset();
        rnd_data = 1'b1;
        v_mode = '{2, 2}; r_mode = '{2, 2}; in_lim = '{1200, 60};
        run_until_out(0, 150, 20000);
        run_until_out(1, 9, 2000);
        check("d0_rand_last_count", 128'(lasts[0]), 128'd3);
        check("d1_rand_last_count", 128'(lasts[1]), 128'd3);

        // Reset mid-frame after 13 elements, then a clean frame.
        do_reset();
        rnd_data = 1'b0;
        v_mode = '{1, 1}; r_mode = '{1, 1}; in_lim = '{13, 13};
        run(20);
        check("d0_pre_reset_sent", 128'(sent[0]), 128'd13);
        do_reset();
        in_lim = '{400, 20};
        run_until_out(0, 50, 600);
        run_until_out(1, 3, 50);
        check("d0_post_reset_last", 128'(lasts[0]), 128'd1);
        check("d1_post_reset_last", 128'(lasts[1]), 128'd1);
        check("d0_post_reset_beat0", obs0.size() > 0 ? obs0[0] : 128'd0,
              128'h0008_0007_0006_0005_0004_0003_0002_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
